pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter stage sitting directly downstream of the branch comparator and control decoder. Consumes `branch_taken` plus jump decode and immediate, computes the next fetch address and holds the architectural PC in a register. Adds a boot cycle after reset, a misaligned-target trap that freezes fetch, and an optional retired-instruction counter.

## Interface
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_en`  in  1  advance enable; 0 = stall, PC holds.
- `branch_taken`  in  1  from branch unit; conditional branch resolved taken.
- `jump`  in  1  JAL decoded.
- `jalr`  in  1  JALR decoded.
- `imm`  in  32  sign-extended immediate (B/J/I format as decoded).
- `ru_X1`  in  32  rs1 value, JALR base.
- `pc`  out  32  current fetch address (registered).
- `pc_plus4`  out  32  `pc + 4` (combinational), link value for JAL/JALR.
- `next_pc`  out  32  selected next address (combinational).
- `pc_valid`  out  1  high only in RUN (registered).
- `trap`  out  1  sticky misaligned-target flag (registered).
- `trap_addr`  out  32  offending target captured at trap (registered).

## Operation
- Target selection, priority high to low:
  - `jalr`: `(ru_X1 + imm) & 32'hFFFF_FFFE`.
  - `jump`: `pc + imm`.
  - `branch_taken`: `pc + imm`.
  - otherwise `pc + 4`.
- All adds are 32-bit modulo 2^32; carry discarded (0xFFFF_FFFC + 4 = 0x0000_0000).
- Misaligned: selected target bit[1] set (bit[0] cleared for JALR, must be 0 otherwise; any nonzero [1:0] is misaligned).
- FSM, states BOOT, RUN, HALT:
  - BOOT: `pc = PC_RESET`, `pc_valid = 0`; next edge -> RUN unconditionally, PC unchanged.
  - RUN: on edge with `pc_en = 1` and aligned target, `pc <= next_pc`. With `pc_en = 1` and misaligned target: `pc` holds, `trap <= 1`, `trap_addr <= target`, -> HALT. With `pc_en = 0`: nothing changes, no trap evaluated.
  - HALT: `pc`, `trap_addr` frozen; `trap = 1`, `pc_valid = 0`; exits only via `rst`.
- Simultaneous `jalr`, `jump`, `branch_taken`: priority above decides; no error.
- Decode inputs are ignored in BOOT and HALT.

## Timing
- Reset (async, immediate): state BOOT, `pc = PC_RESET`, `pc_valid = 0`, `trap = 0`, `trap_addr = 0`, counter (if present) 0.
- `rst` asserted mid-RUN or in HALT: all registers return to reset values without waiting for an edge.
- `pc_valid` rises on the first edge after `rst` deassertion; first PC update occurs on the second edge.
- One-cycle latency: inputs sampled at edge N appear on `pc` after edge N.
- `next_pc`/`pc_plus4` are combinational from `pc`, `imm`, `ru_X1`, decode; valid in every state (value undefined for use outside RUN).
- Trap asserts on the same edge the misaligned target would have been loaded.

## Configuration
- `PC_INSTRET_EN` defined: adds output `instret  out  32`, counting edges in RUN with `pc_en = 1` and aligned target (retired instructions); wraps 0xFFFF_FFFF -> 0; reset 0; frozen in HALT and BOOT.
- Undefined: no `instret` port, no counter logic.

## Test plan
- Reset/boot: `PC_RESET = 0x100`, release `rst` -> `pc = 0x100`, `pc_valid = 0`; edge 1 -> `pc_valid = 1`, `pc = 0x100`; edge 2 -> `pc = 0x104`.
- Branch: `pc = 0x200`, `branch_taken = 1`, `imm = -8` -> `next_pc = 0x1F8`, loaded next edge; same with `pc_en = 0` -> `pc` stays 0x200.
- Priority/JALR: `jalr = jump = branch_taken = 1`, `ru_X1 = 0x1001`, `imm = 4` -> target 0x1004 (bit0 cleared), no trap; `pc_plus4 = pc + 4`.
- Misaligned trap: `jump = 1`, `pc = 0x40`, `imm = 6` -> edge: `trap = 1`, `trap_addr = 0x46`, `pc = 0x40`, `pc_valid = 0`; further stimulus ignored; `rst` clears all.
- Wrap: `pc = 0xFFFF_FFFC`, no control -> `pc = 0x0000_0000`, no trap.
- With `PC_INSTRET_EN`: 5 enabled sequential edges, 2 stalled -> `instret = 5`; trap edge not counted.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter stage: next-fetch selection, boot cycle and misaligned-target trap.
// Optional retired-instruction counter enabled by defining PC_INSTRET_EN.
module pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_en,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] ru_X1,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        pc_valid,
    output logic        trap,
    output logic [31:0] trap_addr
`ifdef PC_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic        pc_valid_r;
    logic        trap_r;
    logic [31:0] trap_addr_r;
    logic [31:0] rel_target_s;
    logic [31:0] jalr_target_s;
    logic [31:0] target_s;
    logic        load_s;
    logic        trap_set_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    assign pc_plus4      = pc_r + 32'd4;
    assign rel_target_s  = pc_r + imm;
    assign jalr_target_s = (ru_X1 + imm) & 32'hFFFF_FFFE;

    // Target selection: jalr over jump over taken branch over sequential
    always_comb begin
        target_s = pc_plus4;
        if (jalr) begin
            target_s = jalr_target_s;
        end else if (jump || branch_taken) begin
            target_s = rel_target_s;
        end else begin
            target_s = pc_plus4;
        end
    end

    assign next_pc = target_s;

    // FSM next state plus PC-load / trap-capture decisions
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        trap_set_s  = 1'b0;
        case (state_r)
            BOOT: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (pc_en) begin
                    if (is_misaligned(target_s)) begin
                        trap_set_s  = 1'b1;
                        state_nxt_s = HALT;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HALT: begin
                state_nxt_s = HALT;
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // State, PC and trap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= BOOT;
            pc_r        <= PC_RESET;
            pc_valid_r  <= 1'b0;
            trap_r      <= 1'b0;
            trap_addr_r <= 32'h0000_0000;
        end else begin
            state_r    <= state_nxt_s;
            pc_valid_r <= (state_nxt_s == RUN);
            if (load_s) begin
                pc_r <= target_s;
            end
            if (trap_set_s) begin
                trap_r      <= 1'b1;
                trap_addr_r <= target_s;
            end
        end
    end

`ifdef PC_INSTRET_EN
    logic [31:0] instret_r;

    // Retired-instruction count: one per aligned enabled RUN edge, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= 32'h0000_0000;
        end else if (load_s) begin
            instret_r <= instret_r + 32'd1;
        end
    end

    assign instret = instret_r;
`endif

    assign pc        = pc_r;
    assign pc_valid  = pc_valid_r;
    assign trap      = trap_r;
    assign trap_addr = trap_addr_r;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver queues expectations, monitors pop and compare.
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        pc_en;
    logic        branch_taken;
    logic        jump;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] ru_X1;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        pc_valid;
    logic        trap;
    logic [31:0] trap_addr;
`ifdef PC_INSTRET_EN
    logic [31:0] instret;
`endif

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        valid;
        logic        trap;
        logic [31:0] taddr;
        logic [31:0] ret;
    } reg_exp_t;

    typedef struct {
        string       name;
        logic [31:0] nxt;
        logic [31:0] p4;
    } comb_exp_t;

    reg_exp_t  reg_q[$];
    comb_exp_t comb_q[$];
    int        checks;
    int        errors;
    logic [31:0] exp_ret;
    event      reset_ev;

    pc_unit #(.PC_RESET(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_en       (pc_en),
        .branch_taken(branch_taken),
        .jump        (jump),
        .jalr        (jalr),
        .imm         (imm),
        .ru_X1       (ru_X1),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc),
        .pc_valid    (pc_valid),
        .trap        (trap),
        .trap_addr   (trap_addr)
`ifdef PC_INSTRET_EN
        ,
        .instret     (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Registered-output monitor: after each edge, or right after an async reset
    initial begin
        reg_exp_t e;
        forever begin
            @(posedge clk or reset_ev);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                chk(e.name, "pc", pc, e.pc);
                chk(e.name, "pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
                chk(e.name, "trap", {31'd0, trap}, {31'd0, e.trap});
                chk(e.name, "trap_addr", trap_addr, e.taddr);
`ifdef PC_INSTRET_EN
                chk(e.name, "instret", instret, e.ret);
`endif
            end
        end
    end

    // Combinational-output monitor: mid low phase once inputs have settled
    initial begin
        comb_exp_t c;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                chk(c.name, "next_pc", next_pc, c.nxt);
                chk(c.name, "pc_plus4", pc_plus4, c.p4);
            end
        end
    end

    task automatic step(input string nm, input logic en, input logic br, input logic jp, input logic jr,
                        input logic [31:0] im, input logic [31:0] x1,
                        input logic [31:0] e_next, input logic [31:0] e_p4,
                        input logic [31:0] e_pc, input logic e_valid, input logic e_trap,
                        input logic [31:0] e_taddr, input logic retire);
        @(negedge clk);
        rst          = 1'b0;
        pc_en        = en;
        branch_taken = br;
        jump         = jp;
        jalr         = jr;
        imm          = im;
        ru_X1        = x1;
        if (retire) exp_ret = exp_ret + 32'd1;
        comb_q.push_back('{nm, e_next, e_p4});
        reg_q.push_back('{nm, e_pc, e_valid, e_trap, e_taddr, exp_ret});
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        exp_ret = 32'h0000_0000;
        reg_q.push_back('{nm, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000});
        #1;
        -> reset_ev;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        exp_ret      = 32'h0000_0000;
        rst          = 1'b1;
        pc_en        = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jalr         = 1'b0;
        imm          = 32'h0000_0000;
        ru_X1        = 32'h0000_0000;

        do_reset("reset0");
        //   name       en   br   jp   jr   imm           ru_X1         next          pc+4          pc            vld  trp  trap_addr     ret
        step("boot",    1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0104,32'h0000_0104,32'h0000_0100,1'b1,1'b0,32'h0000_0000,1'b0);
        step("seq",     1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0104,32'h0000_0104,32'h0000_0104,1'b1,1'b0,32'h0000_0000,1'b1);
        step("jal",     1'b1,1'b0,1'b1,1'b0,32'h0000_00FC,32'h0000_0000,32'h0000_0200,32'h0000_0108,32'h0000_0200,1'b1,1'b0,32'h0000_0000,1'b1);
        step("br_stall",1'b0,1'b1,1'b0,1'b0,32'hFFFF_FFF8,32'h0000_0000,32'h0000_01F8,32'h0000_0204,32'h0000_0200,1'b1,1'b0,32'h0000_0000,1'b0);
        step("br_taken",1'b1,1'b1,1'b0,1'b0,32'hFFFF_FFF8,32'h0000_0000,32'h0000_01F8,32'h0000_0204,32'h0000_01F8,1'b1,1'b0,32'h0000_0000,1'b1);
        step("prio",    1'b1,1'b1,1'b1,1'b1,32'h0000_0004,32'h0000_1001,32'h0000_1004,32'h0000_01FC,32'h0000_1004,1'b1,1'b0,32'h0000_0000,1'b1);
        step("jalr_top",1'b1,1'b0,1'b0,1'b1,32'h0000_000C,32'hFFFF_FFF0,32'hFFFF_FFFC,32'h0000_1008,32'hFFFF_FFFC,1'b1,1'b0,32'h0000_0000,1'b1);
        step("wrap",    1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,1'b1,1'b0,32'h0000_0000,1'b1);
        step("to_40",   1'b1,1'b0,1'b1,1'b0,32'h0000_0040,32'h0000_0000,32'h0000_0040,32'h0000_0004,32'h0000_0040,1'b1,1'b0,32'h0000_0000,1'b1);
        step("misalign",1'b1,1'b0,1'b1,1'b0,32'h0000_0006,32'h0000_0000,32'h0000_0046,32'h0000_0044,32'h0000_0040,1'b0,1'b1,32'h0000_0046,1'b0);
        step("halted",  1'b1,1'b0,1'b1,1'b0,32'h0000_0008,32'h0000_0000,32'h0000_0048,32'h0000_0044,32'h0000_0040,1'b0,1'b1,32'h0000_0046,1'b0);
        do_reset("reset_halt");
        step("boot2",   1'b0,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0104,32'h0000_0104,32'h0000_0100,1'b1,1'b0,32'h0000_0000,1'b0);
        step("ret1",    1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0104,32'h0000_0104,32'h0000_0104,1'b1,1'b0,32'h0000_0000,1'b1);
        step("ret2",    1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0108,32'h0000_0108,32'h0000_0108,1'b1,1'b0,32'h0000_0000,1'b1);
        step("stall1",  1'b0,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_010C,32'h0000_010C,32'h0000_0108,1'b1,1'b0,32'h0000_0000,1'b0);
        step("ret3",    1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_010C,32'h0000_010C,32'h0000_010C,1'b1,1'b0,32'h0000_0000,1'b1);
        step("stall2",  1'b0,1'b0,1'b1,1'b0,32'h0000_0002,32'h0000_0000,32'h0000_010E,32'h0000_0110,32'h0000_010C,1'b1,1'b0,32'h0000_0000,1'b0);
        step("ret4",    1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0110,32'h0000_0110,32'h0000_0110,1'b1,1'b0,32'h0000_0000,1'b1);
        step("ret5",    1'b1,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0114,32'h0000_0114,32'h0000_0114,1'b1,1'b0,32'h0000_0000,1'b1);
        step("trap2",   1'b1,1'b0,1'b1,1'b0,32'h0000_0002,32'h0000_0000,32'h0000_0116,32'h0000_0118,32'h0000_0114,1'b0,1'b1,32'h0000_0116,1'b0);
        step("run_pre", 1'b0,1'b0,1'b0,1'b0,32'h0000_0000,32'h0000_0000,32'h0000_0118,32'h0000_0118,32'h0000_0114,1'b0,1'b1,32'h0000_0116,1'b0);
        do_reset("reset_end");

        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (reg_q.size() != 0 || comb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain actual=%0d pending expected=0", reg_q.size() + comb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
